// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and widths for the fetch stage
// Contents: PC_W, INSTR_W, fetch_state_t (fetch FSM states), br_cond_t.
// Macro PC_FETCH_TIMEOUT_EN adds the FAULT state to fetch_state_t.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
`ifdef PC_FETCH_TIMEOUT_EN
    ,
    FAULT = 3'd5
`endif
  } fetch_state_t;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_EQ     = 2'd1,
    BR_NE     = 2'd2,
    BR_ALWAYS = 2'd3
  } br_cond_t;

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction memory and decode handshake bundle for pc_fetch
// Signals: imem_req/imem_addr (read strobe/address), imem_rdata/imem_rvalid
// (read return), instr/instr_valid/instr_ready (toward decode), halt (from decode).
// Modports: master = fetch stage, slave = memory plus decode side.
interface pc_fetch_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               halt;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_rdata, imem_rvalid, instr_ready, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_rdata, imem_rvalid, instr_ready, halt
  );

endinterface

// File: rtl/pc_fetch_watchdog.sv
// rtl/pc_fetch_watchdog.sv - WAIT-cycle counter and limit compare for pc_fetch
// Ports: clk, rst (sync active-high), start (clears count; asserted the cycle
// before WAIT is entered), active (currently in WAIT), expired (this is the
// TIMEOUT_CYCLES-th WAIT cycle).
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of WAIT cycles already completed without data.
  assign expired = active && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= '0;
    end else if (active && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and single-outstanding instruction fetch FSM
// Ports: clk, rst (sync active-high), pc_next (from PC control), pc_cur
// (registered PC), halted (sticky), fault (sticky timeout), bus (pc_fetch_if.master).
// Macro PC_FETCH_TIMEOUT_EN enables the WAIT timeout and the FAULT state.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC       = 16'h0000,
  parameter int              TIMEOUT_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] pc_cur,
  output logic            halted,
  output logic            fault,
  pc_fetch_if.master      bus
);

  fetch_state_t state;

  assign bus.imem_addr = pc_cur;

`ifdef PC_FETCH_TIMEOUT_EN
  logic wd_expired;

  // REQ is always followed by WAIT, so clearing during REQ clears on WAIT entry.
  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (state == REQ),
    .active (state == WAIT),
    .expired(wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Outputs are registered: each transition sets the strobes of the state it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc_cur          <= RESET_PC;
      bus.instr       <= '0;
      bus.instr_valid <= 1'b0;
      bus.imem_req    <= 1'b0;
      halted          <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
      fault           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state        <= REQ;
          bus.imem_req <= 1'b1;
        end
        REQ: begin
          // Any read return arriving here is stale and ignored.
          state        <= WAIT;
          bus.imem_req <= 1'b0;
        end
        WAIT: begin
          // Data in the limit cycle still wins over the timeout.
          if (bus.imem_rvalid) begin
            bus.instr       <= bus.imem_rdata;
            bus.instr_valid <= 1'b1;
            state           <= HOLD;
          end
`ifdef PC_FETCH_TIMEOUT_EN
          else if (wd_expired) begin
            state <= FAULT;
            fault <= 1'b1;
          end
`endif
        end
        HOLD: begin
          if (bus.instr_ready) begin
            pc_cur          <= pc_next;
            bus.instr_valid <= 1'b0;
            if (bus.halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state        <= REQ;
              bus.imem_req <= 1'b1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
`ifdef PC_FETCH_TIMEOUT_EN
        FAULT: begin
          state <= FAULT;
        end
`endif
        default: begin
          state           <= IDLE;
          bus.imem_req    <= 1'b0;
          bus.instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef PC_FETCH_TIMEOUT_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - self-checking bench for pc_fetch
// Rule-level model updated each rising edge from the inputs, compared every
// cycle 1 time unit after the edge, plus directed literal checks at falling edges.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_next = 16'h0000;
  logic [15:0] pc_cur;
  logic        halted;
  logic        fault;

  pc_fetch_if bus ();

  pc_fetch #(
    .RESET_PC      (16'h0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pc_next(pc_next),
    .pc_cur (pc_cur),
    .halted (halted),
    .fault  (fault),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_pc, m_instr;
  bit m_live = 0, m_valid, m_req, m_halted, m_fault, m_idle, m_wait;
  int m_wcnt;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 0; m_req = 0;
      m_halted = 0; m_fault = 0; m_idle = 1; m_wait = 0; m_wcnt = 0;
    end else if (m_live && !m_halted && !m_fault) begin
      if (m_idle) begin
        m_idle = 0; m_req = 1;
      end else if (m_req) begin
        m_req = 0; m_wait = 1; m_wcnt = 0;
      end else if (m_wait) begin
        if (bus.imem_rvalid) begin
          m_instr = bus.imem_rdata; m_valid = 1; m_wait = 0;
        end else begin
          m_wcnt++;
`ifdef PC_FETCH_TIMEOUT_EN
          if (m_wcnt == 8) begin m_fault = 1; m_wait = 0; end
`endif
        end
      end else if (m_valid && bus.instr_ready) begin
        m_pc = pc_next; m_valid = 0;
        if (bus.halt) m_halted = 1;
        else m_req = 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (m_live) begin
        chk("pc_cur", pc_cur, m_pc);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("imem_req", {15'd0, bus.imem_req}, {15'd0, m_req});
        chk("instr", bus.instr, m_instr);
        chk("instr_valid", {15'd0, bus.instr_valid}, {15'd0, m_valid});
        chk("halted", {15'd0, halted}, {15'd0, m_halted});
        chk("fault", {15'd0, fault}, {15'd0, m_fault});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.imem_req === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("req_wait_timeout", {15'd0, seen}, 16'd1);
  endtask

  // Called at the falling edge inside REQ; ends at the falling edge inside HOLD.
  task automatic fetch(input logic [15:0] data, input int delay, input bit junk);
    if (junk) begin bus.imem_rvalid = 1'b1; bus.imem_rdata = 16'hDEAD; end
    cyc(1);
    bus.imem_rvalid = 1'b0;
    repeat (delay) cyc(1);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = data;
    cyc(1);
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 16'h0000;
  endtask

  task automatic handshake(input logic [15:0] nxt, input bit h, input int stall);
    for (int s = 0; s < stall; s++) begin
      bus.instr_ready = 1'b0; bus.halt = 1'b1; pc_next = 16'($urandom);
      cyc(1);
    end
    bus.instr_ready = 1'b1; bus.halt = h; pc_next = nxt;
    cyc(1);
    bus.instr_ready = 1'b0; bus.halt = 1'b0;
  endtask

  initial begin
    int req_seen;
    bus.imem_rdata = 16'h0000; bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b0; bus.halt = 1'b0;

    // Reset state and first fetch
    cyc(2);
    chk("rst_pc", pc_cur, 16'h0000);
    chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
    chk("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    rst = 1'b0;
    wait_req();
    chk("first_addr", bus.imem_addr, 16'h0000);
    fetch(16'h1234, 1, 0);
    chk("first_instr", bus.instr, 16'h1234);
    chk("first_valid", {15'd0, bus.instr_valid}, 16'd1);

    // Stall 3 cycles, then handshake
    handshake(16'h0010, 0, 3);
    chk("after_stall_pc", pc_cur, 16'h0010);
    chk("after_stall_req", {15'd0, bus.imem_req}, 16'd1);

    // Stale return in REQ ignored; branch to 0x0040
    fetch(16'h5555, 1, 1);
    chk("junk_ignored", bus.instr, 16'h5555);
    handshake(16'h0040, 0, 0);
    chk("branch_addr", bus.imem_addr, 16'h0040);

    // Wrap
    fetch(16'h0A0A, 0, 0);
    handshake(16'hFFFE, 0, 1);
    fetch(16'h0B0B, 2, 0);
    handshake(16'h0000, 0, 0);
    chk("wrap_addr", bus.imem_addr, 16'h0000);

    // Halt
    fetch(16'h0C0C, 0, 0);
    handshake(16'h0022, 1, 0);
    chk("halted", {15'd0, halted}, 16'd1);
    chk("halt_pc", pc_cur, 16'h0022);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      bus.instr_ready = 1'($urandom); bus.halt = 1'($urandom);
      bus.imem_rvalid = 1'($urandom); bus.imem_rdata = 16'($urandom);
      cyc(1);
      if (bus.imem_req === 1'b1) req_seen++;
    end
    chk("halt_no_req", 16'(req_seen), 16'd0);
    bus.instr_ready = 1'b0; bus.halt = 1'b0; bus.imem_rvalid = 1'b0;

    // Recover from halt
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("recover_halted", {15'd0, halted}, 16'd0);
    chk("recover_pc", pc_cur, 16'h0000);
    wait_req();

    // Reset while in WAIT, return arrives in IDLE
    cyc(1);
    rst = 1'b1; cyc(1);
    rst = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 16'hBEEF;
    cyc(1);
    bus.imem_rvalid = 1'b0;
    chk("midrst_instr", bus.instr, 16'h0000);
    chk("midrst_valid", {15'd0, bus.instr_valid}, 16'd0);
    chk("midrst_req", {15'd0, bus.imem_req}, 16'd1);
    chk("midrst_addr", bus.imem_addr, 16'h0000);

    // No return at all
    cyc(12);
`ifdef PC_FETCH_TIMEOUT_EN
    chk("timeout_fault", {15'd0, fault}, 16'd1);
`else
    chk("timeout_fault", {15'd0, fault}, 16'd0);
`endif
    chk("timeout_valid", {15'd0, bus.instr_valid}, 16'd0);
    chk("timeout_req", {15'd0, bus.imem_req}, 16'd0);

    // Reset clears everything; one more clean fetch
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("final_fault", {15'd0, fault}, 16'd0);
    wait_req();
    fetch(16'h7777, 0, 0);
    handshake(16'h0002, 0, 0);
    chk("final_pc", pc_cur, 16'h0002);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 8: WAIT cycles before fault; used only when the macro in REQ-031 is defined.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pc_next  in  16  next PC from the branch/PC control stage, computed from pc_cur.
REQ-006 pc_cur  out  16  current PC, registered; drives the PC control stage input and the fetch address.
REQ-007 imem_req  out  1  one-cycle instruction memory read strobe.
REQ-008 imem_addr  out  16  read address; equals pc_cur.
REQ-009 imem_rdata  in  16  read data, valid when imem_rvalid=1.
REQ-010 imem_rvalid  in  1  read data valid.
REQ-011 instr  out  16  fetched instruction, registered.
REQ-012 instr_valid  out  1  instr is valid toward decode.
REQ-013 instr_ready  in  1  decode accepts instr.
REQ-014 halt  in  1  decode flags the presented instruction as halt.
REQ-015 halted  out  1  sticky; fetch stopped.
REQ-016 fault  out  1  sticky memory-timeout flag.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, HOLD, HALT, and FAULT (FAULT exists only with macro).
REQ-018 IDLE: all strobes low; next state is REQ.
REQ-019 REQ: imem_req=1 for exactly one cycle, imem_addr=pc_cur; next state is WAIT; imem_rvalid in REQ is ignored.
REQ-020 WAIT: on imem_rvalid=1, instr<=imem_rdata and next state is HOLD; otherwise remain in WAIT.
REQ-021 HOLD: instr_valid=1; instr and pc_cur stable while instr_ready=0 (no new imem_req).
REQ-022 HOLD with instr_ready=1 (handshake): pc_cur<=pc_next; next state is HALT if halt=1, else REQ.
REQ-023 Latency: instr_valid rises the cycle after imem_rvalid; the next imem_req occurs the cycle after the handshake.
REQ-024 halt is sampled only on a HOLD handshake; it is ignored in all other states.
REQ-025 HALT: halted=1, imem_req=0, instr_valid=0; remain until rst.
REQ-026 The PC is updated only on a handshake; 16-bit wrap of pc_next (0xFFFE->0x0000) is passed through unmodified.
REQ-027 instr_valid is low in every state except HOLD.

Reset
REQ-028 rst=1: state<=IDLE, pc_cur<=RESET_PC, instr<=16'h0000, instr_valid=0, imem_req=0, halted=0, fault=0.
REQ-029 rst takes priority over every other input, in every state including HALT and FAULT.
REQ-030 Reset mid-read: any imem_rvalid arriving while in IDLE after reset is ignored.

Configuration
REQ-031 Macro PC_FETCH_TIMEOUT_EN: when defined, a counter counts WAIT cycles. When it reaches TIMEOUT_CYCLES without imem_rvalid, next state is FAULT with fault=1 and imem_req=0, sticky until rst. When undefined, fault is tied 0, FAULT does not exist, and WAIT waits indefinitely.
REQ-032 The counter clears on entry to WAIT; imem_rvalid in the same cycle the limit is reached wins and proceeds to HOLD.

Structure
REQ-033 Shared package cpu_pkg holds PC_W=16, INSTR_W=16, and enum fetch_state_t, alongside the existing branch-condition enum.
REQ-034 Sub-module fetch_watchdog (counter plus compare) is instantiated only under PC_FETCH_TIMEOUT_EN; all other logic is inline.

Verification
REQ-035 Reset with RESET_PC=0x0000, release, memory returns 0x1234 two cycles after the request -> IDLE 1 cycle; imem_req with addr 0x0000; instr=0x1234, instr_valid=1 the cycle after rvalid.
REQ-036 instr_ready held 0 for 3 cycles in HOLD -> instr_valid stays 1, instr and pc_cur unchanged, no imem_req; the handshake on cycle 4 loads pc_next.
REQ-037 pc_cur=0x0010, pc_next=0x0040 at handshake -> next imem_addr=0x0040; pc_next=0x0000 from pc_cur 0xFFFE -> addr 0x0000.
REQ-038 halt=1 with handshake, pc_next=0x0022 -> halted=1 next cycle, pc_cur=0x0022, no imem_req for 20 cycles; rst recovers to RESET_PC.
REQ-039 rst asserted in WAIT, imem_rvalid=1 with data 0xBEEF the cycle after -> instr=0x0000, instr_valid=0, refetch from RESET_PC.
REQ-040 No imem_rvalid: with PC_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8 -> fault=1 after 8 WAIT cycles and stays 1; without the macro -> fault=0 and the FSM remains in WAIT.
